// File: rtl/key_expansion_pkg.sv
// Shared AES-128 constants, state encoding and GF(2^8) helper for the key
// schedule, AddRoundKey and round datapath.
package key_expansion_pkg;

    localparam int AES_NK       = 4;
    localparam int AES_NR       = 10;
    localparam int AES_NWORDS   = AES_NK * (AES_NR + 1);
    localparam int AES_EXPKEY_W = 32 * AES_NWORDS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } ke_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_expansion_if.sv
// Key-schedule request/result bundle: cipher key and start in,
// expanded key and finish out.
interface key_expansion_if;
    import key_expansion_pkg::*;

    logic [127:0]              key;
    logic                      start;
    logic [AES_EXPKEY_W-1:0]   expanded_key;
    logic                      finish;

    modport master (output key, start, input expanded_key, finish);
    modport slave  (input key, start, output expanded_key, finish);
endinterface

// File: rtl/key_expansion_sbox.sv
// Combinational AES forward S-box (8 -> 8); also reused by SubBytes.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];
endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: one 32-bit word per clock into the
// 1408-bit expanded-key register, w[0] in the most significant word.
module key_expansion
    import key_expansion_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    key_expansion_if.slave   bus
);
    ke_state_t                    state;
    logic [0:AES_NWORDS-1][31:0]  w_q;
    logic [5:0]                   i;
    logic [7:0]                   rcon;
    logic                         finish_q;

    logic [31:0] prev_word;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] temp;
    logic [31:0] new_word;

    assign prev_word = w_q[i - 6'd1];
    assign rot_word  = {prev_word[23:0], prev_word[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .a (rot_word[8*b +: 8]),
            .y (sub_word[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev_word;
        if (i[1:0] == 2'b00) begin
            temp = sub_word ^ {rcon, 24'h0};
        end
        new_word = w_q[i - 6'(AES_NK)] ^ temp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            w_q      <= '0;
            finish_q <= 1'b0;
            i        <= '0;
            rcon     <= 8'h01;
        end else begin
            case (state)
                ST_IDLE: begin
                    finish_q <= 1'b0;
                    if (bus.start) begin
                        w_q[0:AES_NK-1] <= bus.key;
                        i               <= 6'(AES_NK);
                        rcon            <= 8'h01;
                        state           <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    w_q[i] <= new_word;
                    i      <= i + 6'd1;
                    if (i[1:0] == 2'b00) begin
                        rcon <= xtime(rcon);
                    end
                    if (i == 6'(AES_NWORDS - 1)) begin
                        state    <= ST_DONE;
                        finish_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // start must be released before another run can begin
                    if (!bus.start) begin
                        state    <= ST_IDLE;
                        finish_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    finish_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.expanded_key = w_q;
    assign bus.finish       = finish_q;
endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: known-answer vectors, latency,
// mid-run reset and start/finish handshake.
module tb_key_expansion;
    logic clk = 1'b0;
    logic rst;

    key_expansion_if bus ();

    key_expansion dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    typedef struct {
        logic [127:0] rk1;
        logic [127:0] rk10;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_TEAM = 128'h657870616E642033322D62797465206B;

    function automatic logic [127:0] rk(input logic [1407:0] ek, input int r);
        return ek[1407 - 128*r -: 128];
    endfunction

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic chk_int(input string n, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start with a key (edge E0) and records the expected schedule.
    task automatic launch(input logic [127:0] k, input logic [127:0] rk1, input logic [127:0] rk10);
        exp_t e;
        e.rk1  = rk1;
        e.rk10 = rk10;
        bus.key   = k;
        bus.start = 1'b1;
        sb.push_back(e);
        tick();
        chk("w0_3_loaded", rk(bus.expanded_key, 0), k);
    endtask

    // Waits (bounded) for finish; lat0 edges after E0 have already elapsed.
    task automatic collect(input string tag, input int lat0);
        int   lat;
        exp_t e;
        lat = lat0;
        while (bus.finish !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk_int({tag, "_latency"}, lat, 40);
        if (sb.size() == 0) begin
            chk_int({tag, "_scoreboard_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rk1"},  rk(bus.expanded_key, 1),  e.rk1);
            chk({tag, "_rk10"}, rk(bus.expanded_key, 10), e.rk10);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[3];
        vecs[0] = '{"fips_a1", KEY_A1,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{"team", KEY_TEAM,
                    128'h29CF0FF347AB2FC075864DB901E36DD2,
                    128'h782A7509F13D56612EA71A5815280270};
        vecs[2] = '{"zero", 128'h0,
                    128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.key   = '0;
        tick();
        tick();
        chk_int("reset_finish", int'(bus.finish), 0);
        chk_int("reset_ek_ones", $countones(bus.expanded_key), 0);
        rst = 1'b0;
        tick();

        // First run after reset: round 2 must still be empty at E4.
        for (int v = 0; v < 3; v++) begin
            bus.start = 1'b0;
            tick();
            chk_int({vecs[v].name, "_idle_finish"}, int'(bus.finish), 0);
            launch(vecs[v].key, vecs[v].rk1, vecs[v].rk10);
            repeat (4) tick();
            chk({vecs[v].name, "_rk1_at_E4"}, rk(bus.expanded_key, 1), vecs[v].rk1);
            if (v == 0) begin
                chk("rk2_empty_at_E4", rk(bus.expanded_key, 2), 128'h0);
            end
            chk_int({vecs[v].name, "_finish_low_E4"}, int'(bus.finish), 0);
            collect(vecs[v].name, 4);
            bus.start = 1'b0;
            tick();
            chk_int({vecs[v].name, "_finish_falls"}, int'(bus.finish), 0);
            chk({vecs[v].name, "_rk10_retained"}, rk(bus.expanded_key, 10), vecs[v].rk10);
        end

        // Reset after 20 EXPAND cycles, then a clean rerun of A.1.
        launch(KEY_A1, vecs[0].rk1, vecs[0].rk10);
        repeat (20) tick();
        rst       = 1'b1;
        bus.start = 1'b0;
        tick();
        chk_int("midrst_finish", int'(bus.finish), 0);
        chk_int("midrst_ek_ones", $countones(bus.expanded_key), 0);
        void'(sb.pop_front());
        rst = 1'b0;
        tick();
        launch(KEY_A1, vecs[0].rk1, vecs[0].rk10);
        collect("after_rst", 0);

        // Key change during EXPAND and start held past DONE.
        bus.start = 1'b0;
        tick();
        launch(KEY_A1, vecs[0].rk1, vecs[0].rk10);
        repeat (10) tick();
        bus.key = KEY_TEAM;
        collect("key_change", 10);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_int("held_finish", int'(bus.finish), 1);
            chk("held_rk10", rk(bus.expanded_key, 10), vecs[0].rk10);
        end

        // One-cycle start drop, then rerun with the team key.
        bus.start = 1'b0;
        tick();
        chk_int("drop_finish", int'(bus.finish), 0);
        launch(KEY_TEAM, vecs[1].rk1, vecs[1].rk10);
        chk_int("rerun_finish_low", int'(bus.finish), 0);
        collect("rerun", 0);

        chk_int("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
